gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Clocked, self-checking exhaustive stimulus engine for N-input reduction gates. This is the parametrised successor to the free-running toggle stimulus used for the 3-input OR gate.
- Drives every input combination onto a gate under test. Each pattern is held for a programmable number of cycles, and the DUT output is compared against a golden reduction selected by mode.
- Counts mismatches, captures the first failing pattern, and reports pass/done.
- Sits between a top-level test harness and any combinational gate DUT.

Parameters:
- N_IN, 3, number of DUT inputs (1..16); sweep length 2^N_IN patterns.
- HOLD, 2, cycles each pattern is held (≥1); DUT output sampled on last hold cycle.
- ERR_W, 8, width of saturating mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin sweep; accepted only in IDLE.
- mode  in  2  golden function: 0=OR, 1=AND, 2=XOR, 3=NOR; latched on accepted start.
- pat  out  N_IN  pattern to DUT; pat[N_IN-1] slowest-changing bit, pat[0] fastest.
- dut_y  in  1  DUT output (combinational from pat).
- busy  out  1  high while sweep active.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 when last sweep had err_cnt==0; held until next accepted start.
- err_cnt  out  ERR_W  mismatch count, saturates at all-ones.
- first_err_pat  out  N_IN  pattern of first mismatch.
- first_err_valid  out  1  first_err_pat holds a valid capture.

Behaviour:
- Reset: clk edge with rst_n=0 forces state IDLE and clears all outputs: pat, busy, done, pass, err_cnt, first_err_pat, first_err_valid = 0. The same applies mid-sweep; the sweep is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 (edge t).
  - On that edge: mode latched, pat=0, hold_cnt=0, err_cnt=0, first_err_valid=0, first_err_pat=0, pass=0, busy=1.
- RUN, per cycle:
  - If hold_cnt<HOLD-1: hold_cnt++.
  - Else (sample cycle): compare dut_y with expected=f(mode,pat).
    - On mismatch: err_cnt++ unless all-ones. If first_err_valid=0, capture first_err_pat=pat and set first_err_valid=1.
    - Then hold_cnt=0 and pat advances to the next pattern.
  - After sampling the final pattern (binary 2^N_IN-1): pat returns to 0, busy=0, done=1, pass=(next err_cnt==0), state DONE.
- DONE -> IDLE unconditionally next edge; done=0. start is ignored in DONE and RUN (no restart, no effect on counters).
- Timing: busy high for exactly 2^N_IN*HOLD cycles. done asserted in cycle t+1+2^N_IN*HOLD, relative to the start edge.
- Expected reductions over the N_IN bits of pat:
  - OR = |pat
  - AND = &pat
  - XOR = ^pat
  - NOR = ~|pat
- The mode input may change during RUN without effect.
- err_cnt, first_err_*, and pass hold their values in IDLE until the next accepted start or reset.
- The mismatch on the final pattern is included in both err_cnt and pass.

Optional Feature:
- SWEEP_GRAY_EN defined: pat steps in reflected Gray order, pat = b ^ (b>>1) where b is the internal binary index. Only one DUT input changes per step (glitch-free stimulus). Expected value and first_err_pat use the applied Gray pattern. The sweep ends after index 2^N_IN-1.
- Undefined: pat equals the plain binary index (0,1,2,...).
- Timing is identical in both cases.

Test Plan:
- N_IN=3, HOLD=2, mode=0, dut_y=|pat model, start pulse:
  - pat sequence 0..7, each held 2 cycles.
  - busy=1 for 16 cycles; done pulse on the 17th cycle after start edge.
  - err_cnt=0, pass=1, first_err_valid=0.
- Same configuration, dut_y stuck at 0:
  - err_cnt=7, first_err_pat=3'b001, first_err_valid=1, pass=0.
- mode=2 (XOR), dut_y driven by OR model:
  - Mismatches at pat 3,5,6 → err_cnt=3, first_err_pat=3'b011, pass=0.
- ERR_W=2, dut_y=~expected:
  - 8 mismatches → err_cnt saturates at 2'b11, first_err_pat=0.
- Control and reset:
  - start re-pulsed during RUN → sequence and counters unaffected.
  - rst_n=0 at pattern 4 → next edge all outputs 0, state IDLE, no done pulse.
  - A new start then restarts from pat=0.
- With SWEEP_GRAY_EN, N_IN=3:
  - pat sequence 0,1,3,2,6,7,5,4; exactly one bit changes per step.
  - mode=3 with a NOR model → pass=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine for N-input reduction gates: sweeps every pattern, compares DUT output to a golden reduction.
// Define SWEEP_GRAY_EN to step patterns in reflected Gray order instead of plain binary.
module gate_sweep_checker #(
  parameter int N_IN  = 3,
  parameter int HOLD  = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N_IN-1:0]  pat,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_pat,
  output logic             first_err_valid
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [N_IN-1:0]   fpat_q, fpat_d;
  logic              fval_q, fval_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   pat_w;
  logic              mismatch;

`ifdef SWEEP_GRAY_EN
  assign pat_w = idx_q ^ (idx_q >> 1);
`else
  assign pat_w = idx_q;
`endif

  function automatic logic golden(input logic [1:0] m, input logic [N_IN-1:0] p);
    case (m)
      2'd0:    return |p;
      2'd1:    return &p;
      2'd2:    return ^p;
      default: return ~|p;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fpat_q  <= '0;
      fval_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fpat_q  <= fpat_d;
      fval_q  <= fval_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    err_d    = err_q;
    fpat_d   = fpat_q;
    fval_d   = fval_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          mode_d  = mode;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          fpat_d  = '0;
          fval_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          hold_d   = '0;
          mismatch = (dut_y != golden(mode_q, pat_w));
          if (mismatch) begin
            err_d = sat_inc(err_q);
            if (!fval_q) begin
              fpat_d = pat_w;
              fval_d = 1'b1;
            end
          end
          // index wraps to zero after the final pattern, leaving pat parked at 0
          idx_d = idx_q + 1'b1;
          if (&idx_q) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q == S_RUN);
    done            = (state_q == S_DONE);
    pat             = pat_w;
    pass            = pass_q;
    err_cnt         = err_q;
    first_err_pat   = fpat_q;
    first_err_valid = fval_q;
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a table-driven gate model, a countones-based reference and a done-triggered monitor.
module tb_gate_sweep_checker;
  localparam int N_IN  = 3;
  localparam int HOLD  = 2;
  localparam int ERR_W = 8;
  localparam int NP    = 1 << N_IN;
  localparam int M     = NP * HOLD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] sweep_mode = 2'd0;

  logic [N_IN-1:0]  pat, first_err_pat;
  logic             dut_y, busy, done, pass, first_err_valid;
  logic [ERR_W-1:0] err_cnt;

  logic [N_IN-1:0]  pat2, first_err_pat2;
  logic             dut_y2, busy2, done2, pass2, first_err_valid2;
  logic [1:0]       err_cnt2;

  logic resp [NP];

  typedef struct packed {
    logic [ERR_W-1:0] err;
    logic [N_IN-1:0]  fpat;
    logic             fval;
    logic             pass;
  } res_t;

  res_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gate_sweep_checker #(.N_IN(N_IN), .HOLD(HOLD), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pat(pat), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_pat(first_err_pat), .first_err_valid(first_err_valid)
  );

  gate_sweep_checker #(.N_IN(N_IN), .HOLD(HOLD), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pat(pat2), .dut_y(dut_y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_err_pat(first_err_pat2), .first_err_valid(first_err_valid2)
  );

  function automatic logic ref_gate(input logic [1:0] m, input logic [N_IN-1:0] p);
    int k;
    k = $countones(p);
    case (m)
      2'd0:    return k != 0;
      2'd1:    return k == N_IN;
      2'd2:    return (k % 2) == 1;
      default: return k == 0;
    endcase
  endfunction

  function automatic logic [N_IN-1:0] order(input int b);
    int g;
`ifdef SWEEP_GRAY_EN
    g = b ^ (b >> 1);
`else
    g = b;
`endif
    return g[N_IN-1:0];
  endfunction

  assign dut_y  = resp[pat];
  assign dut_y2 = ~ref_gate(sweep_mode, pat2);

  function automatic res_t model(input logic [1:0] m);
    res_t r;
    int cnt, maxv;
    logic [N_IN-1:0] p;
    cnt  = 0;
    maxv = (1 << ERR_W) - 1;
    r    = '0;
    for (int b = 0; b < NP; b++) begin
      p = order(b);
      if (resp[p] != ref_gate(m, p)) begin
        cnt++;
        if (!r.fval) begin
          r.fpat = p;
          r.fval = 1'b1;
        end
      end
    end
    r.err  = ERR_W'((cnt > maxv) ? maxv : cnt);
    r.pass = (cnt == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    res_t r;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        r = sb_q.pop_front();
        check("err_cnt", 64'(err_cnt), 64'(r.err));
        check("first_err_pat", 64'(first_err_pat), 64'(r.fpat));
        check("first_err_valid", 64'(first_err_valid), 64'(r.fval));
        check("pass", 64'(pass), 64'(r.pass));
      end
    end
  end

  always @(negedge clk) begin
    int c;
    if (done2 === 1'b1) begin
      c = (NP > 3) ? 3 : NP;
      check("sat_err_cnt", 64'(err_cnt2), 64'(c));
      check("sat_first", 64'({first_err_valid2, first_err_pat2}), 64'({1'b1, order(0)}));
      check("sat_pass_busy", 64'({pass2, busy2}), 64'd0);
    end
  end

  task automatic set_resp(input int kind, input logic [1:0] m);
    for (int p = 0; p < NP; p++) begin
      case (kind)
        0:       resp[p] = ref_gate(m, N_IN'(p));
        1:       resp[p] = 1'b0;
        2:       resp[p] = ref_gate(2'd0, N_IN'(p));
        3:       resp[p] = ref_gate(m, N_IN'(p)) ^ ($urandom_range(0, 3) == 0);
        default: resp[p] = 1'($urandom);
      endcase
    end
  endtask

  task automatic run_sweep(input logic [1:0] m, input bit poke);
    res_t e;
    int poke_at;
    e = model(m);
    poke_at = $urandom_range(1, M - 2);
    @(negedge clk);
    mode = m;
    sweep_mode = m;
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < M; k++) begin
      check("run", 64'({busy, done, pat}), 64'({1'b1, 1'b0, order(k / HOLD)}));
      start = poke && (k == poke_at);
      if (poke) mode = 2'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_cycle", 64'({busy, done, pat}), 64'({1'b0, 1'b1, N_IN'(0)}));
    @(negedge clk);
    check("idle_after", 64'({busy, done}), 64'd0);
    @(negedge clk);
    check("held_result", 64'({err_cnt, pass}), 64'({e.err, e.pass}));
  endtask

  task automatic reset_mid_sweep();
    bit saw;
    set_resp(0, 2'd0);
    @(negedge clk);
    mode = 2'd0;
    sweep_mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 * HOLD) @(negedge clk);
    check("pre_reset_pat", 64'(pat), 64'(order(4)));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_outputs",
          64'({pat, busy, done, pass, err_cnt, first_err_pat, first_err_valid}), 64'd0);
    saw = 1'b0;
    for (int k = 0; k < 2 * M; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    check("no_done_after_reset", 64'(saw), 64'd0);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) resp[p] = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state",
          64'({pat, busy, done, pass, err_cnt, first_err_pat, first_err_valid}), 64'd0);
    rst_n = 1'b1;

    set_resp(0, 2'd0); run_sweep(2'd0, 1'b0);
    set_resp(1, 2'd0); run_sweep(2'd0, 1'b0);
    set_resp(2, 2'd2); run_sweep(2'd2, 1'b1);
    set_resp(0, 2'd3); run_sweep(2'd3, 1'b0);
    reset_mid_sweep();
    set_resp(0, 2'd1); run_sweep(2'd1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [1:0] m;
      m = 2'($urandom);
      set_resp($urandom_range(0, 4), m);
      run_sweep(m, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
